font_rom_arbiter: RTL and testbench
===================================

FONT_ROM_ARBITER -- requirements
Module: font_rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 9, the font ROM address width.
REQ-002 SHALL have parameter FNT_W, default 4, the font ROM data width (one glyph line).
REQ-003 SHALL have parameter ROM_LAT, default 1, the cycles from the ROM sampling an address to rom_q being valid (range 1..4).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its posedge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port disp_req, input, 1, display fetch request (real-time, never refused).
REQ-007 SHALL have port disp_addr, input, ADDR_SIZE, display fetch address.
REQ-008 SHALL have port disp_valid, output, 1, one-cycle pulse marking disp_data valid.
REQ-009 SHALL have port disp_data, output, FNT_W, glyph line returned to the display.
REQ-010 SHALL have port bg_req, input, 1, background request; bg_req and bg_addr are held until bg_gnt.
REQ-011 SHALL have port bg_addr, input, ADDR_SIZE, background fetch address.
REQ-012 SHALL have port bg_gnt, output, 1, one-cycle pulse accepting the current background request.
REQ-013 SHALL have port bg_valid, output, 1, one-cycle pulse marking bg_data valid.
REQ-014 SHALL have port bg_data, output, FNT_W, glyph line returned to the background requester.
REQ-015 SHALL have port rom_clk, output, 1, equal to clk.
REQ-016 SHALL have port rom_addr, output, ADDR_SIZE, registered ROM address.
REQ-017 SHALL have port rom_q, input, FNT_W, ROM read data.

Function
REQ-018 SHALL keep an owner FSM with states IDLE, DISP and BG, which records which requester issued on the last edge.
REQ-019 SHALL, at each edge, go to DISP if disp_req=1, else to BG if bg_req=1, else to IDLE; display has absolute priority.
REQ-020 SHALL load rom_addr from disp_addr in DISP and from bg_addr in BG, and hold rom_addr in IDLE.
REQ-021 SHALL assert bg_gnt combinationally in any cycle where bg_req=1 and disp_req=0.
REQ-022 SHALL allow back-to-back grants, up to one issue per cycle for either requester.
REQ-023 SHALL carry a {valid, owner} tag through a (1+ROM_LAT)-stage shift register.
REQ-024 SHALL, for a request sampled at edge k, capture rom_q into the owner's data register at edge k+1+ROM_LAT and pulse that owner's valid for exactly the following cycle (2-cycle latency at default).
REQ-025 SHALL hold disp_data and bg_data between valid pulses.
REQ-026 SHALL return data to each requester in issue order and never deliver data to the non-issuing requester.
REQ-027 SHALL leave bg_gnt low and ignore bg_addr while disp_req=1, holding background requests for as long as needed, with no timeout.
REQ-028 SHALL treat simultaneous disp_req and bg_req as a display issue, with bg_gnt=0.

Reset
REQ-029 SHALL, while rst=1, force the FSM to IDLE, clear all tags, and hold rom_addr=0, disp_data=0, bg_data=0, disp_valid=0, bg_valid=0 and bg_gnt=0.
REQ-030 SHALL flush in-flight reads on reset mid-operation, with no valid pulse after rst deasserts for any pre-reset issue.
REQ-031 SHALL begin normal arbitration at the first edge after rst deasserts.

Configuration
REQ-032 SHALL, with FONT_ARB_STATS_EN defined, add output bg_stall_cnt (16 bits), which increments saturating at 16'hFFFF on every cycle with bg_req=1 and bg_gnt=0, and clears on reset.
REQ-033 SHALL, without FONT_ARB_STATS_EN, have no bg_stall_cnt port and no counter logic, with all other behaviour identical.

Verification
REQ-034 SHALL verify: disp_req=1, disp_addr=9'h041 at edge 0, ROM model returning 4'hA at that address -> rom_addr=9'h041 after edge 0, disp_valid=1 with disp_data=4'hA in cycle after edge 2.
REQ-035 SHALL verify: bg_req=1, bg_addr=9'h100, disp_req=1 for 5 cycles then 0 -> bg_gnt=0 for 5 cycles, bg_gnt=1 in 6th cycle, bg_valid 2 cycles later, bg_stall_cnt=5 (stats build).
REQ-036 SHALL verify: alternating disp/bg issues every cycle, addresses 0..7 -> each data returned to correct owner in order, no lost or duplicated pulses.
REQ-037 SHALL verify: rst pulsed 1 cycle after a display issue -> no disp_valid follows, all outputs 0, next request served normally.
REQ-038 SHALL verify: ROM_LAT=3, single bg issue -> bg_valid exactly 4 cycles after issue edge.
REQ-039 SHALL verify: bg_req held 70000 cycles under continuous disp_req (stats build) -> bg_stall_cnt saturates at 16'hFFFF, no wrap.

Source files
------------

// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: display-priority font ROM arbiter with tagged read return; FONT_ARB_STATS_EN adds bg_stall_cnt
module font_rom_arbiter #(
  parameter int ADDR_SIZE = 9,
  parameter int FNT_W     = 4,
  parameter int ROM_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 disp_req,
  input  logic [ADDR_SIZE-1:0] disp_addr,
  output logic                 disp_valid,
  output logic [FNT_W-1:0]     disp_data,
  input  logic                 bg_req,
  input  logic [ADDR_SIZE-1:0] bg_addr,
  output logic                 bg_gnt,
  output logic                 bg_valid,
  output logic [FNT_W-1:0]     bg_data,
  output logic                 rom_clk,
  output logic [ADDR_SIZE-1:0] rom_addr,
  input  logic [FNT_W-1:0]     rom_q
`ifdef FONT_ARB_STATS_EN
  ,
  output logic [15:0]          bg_stall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, DISP, BG} state_t;
  state_t state, state_nxt;
  logic [ROM_LAT-1:0] pipe_v, pipe_o;
  logic [ROM_LAT:0] tag_v, tag_o;
  assign rom_clk = clk;
  assign bg_gnt = ~rst & bg_req & ~disp_req;
  // the owner state register doubles as stage 0 of the return tag pipe
  assign tag_v = {pipe_v, state != IDLE};
  assign tag_o = {pipe_o, state == BG};
  always_comb begin
    state_nxt = disp_req ? DISP : bg_req ? BG : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rom_addr   <= '0;
      pipe_v     <= '0;
      pipe_o     <= '0;
      disp_valid <= 1'b0;
      bg_valid   <= 1'b0;
      disp_data  <= '0;
      bg_data    <= '0;
    end else begin
      state      <= state_nxt;
      rom_addr   <= state_nxt == DISP ? disp_addr : state_nxt == BG ? bg_addr : rom_addr;
      pipe_v     <= tag_v[ROM_LAT-1:0];
      pipe_o     <= tag_o[ROM_LAT-1:0];
      disp_valid <= tag_v[ROM_LAT] & ~tag_o[ROM_LAT];
      bg_valid   <= tag_v[ROM_LAT] & tag_o[ROM_LAT];
      if (tag_v[ROM_LAT] & ~tag_o[ROM_LAT]) disp_data <= rom_q;
      if (tag_v[ROM_LAT] & tag_o[ROM_LAT]) bg_data <= rom_q;
    end
  end
`ifdef FONT_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bg_stall_cnt <= '0;
    else if (bg_req & ~bg_gnt & (bg_stall_cnt != 16'hFFFF)) bg_stall_cnt <= bg_stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_font_rom_arbiter.sv
// tb_font_rom_arbiter: vector table, corner sequences and a queue-based random scoreboard
module tb_font_rom_arbiter;
  localparam int AW = 9;
  localparam int FW = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic disp_req = 1'b0, bg_req = 1'b0;
  logic [AW-1:0] disp_addr = '0, bg_addr = '0;
  logic disp_valid, bg_valid, bg_gnt, rom_clk;
  logic [FW-1:0] disp_data, bg_data, rom_q;
  logic [AW-1:0] rom_addr;
  logic zero3 = 1'b0, bg_req3 = 1'b0;
  logic [AW-1:0] bg_addr3 = '0;
  logic dv3, bv3, gnt3, rc3;
  logic [FW-1:0] dd3, bd3, rq3;
  logic [AW-1:0] ra3;
  logic [FW-1:0] p3 [3];
`ifdef FONT_ARB_STATS_EN
  logic [15:0] cnt, cnt3;
`endif
  font_rom_arbiter u0 (
    .clk(clk), .rst(rst), .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_valid(disp_valid), .disp_data(disp_data), .bg_req(bg_req), .bg_addr(bg_addr),
    .bg_gnt(bg_gnt), .bg_valid(bg_valid), .bg_data(bg_data), .rom_clk(rom_clk),
    .rom_addr(rom_addr), .rom_q(rom_q)
`ifdef FONT_ARB_STATS_EN
    , .bg_stall_cnt(cnt)
`endif
  );
  font_rom_arbiter #(.ROM_LAT(3)) u3 (
    .clk(clk), .rst(rst), .disp_req(zero3), .disp_addr(bg_addr3),
    .disp_valid(dv3), .disp_data(dd3), .bg_req(bg_req3), .bg_addr(bg_addr3),
    .bg_gnt(gnt3), .bg_valid(bv3), .bg_data(bd3), .rom_clk(rc3),
    .rom_addr(ra3), .rom_q(rq3)
`ifdef FONT_ARB_STATS_EN
    , .bg_stall_cnt(cnt3)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [FW-1:0] rom_f(logic [AW-1:0] a);
    return a[3:0] ^ a[7:4] ^ {3'b000, a[8]} ^ 4'hF;
  endfunction
  always @(posedge rom_clk) rom_q <= rom_f(rom_addr);
  always @(posedge rc3) begin
    p3[0] <= rom_f(ra3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rq3 = p3[2];
  int checks = 0, errors = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  typedef struct {
    logic dr; logic [8:0] da; logic br; logic [8:0] ba;
    logic gnt; logic [8:0] ra; logic dv; logic [3:0] dd; logic bv; logic [3:0] bd;
  } vec_t;
  vec_t tbl [14];
  typedef struct {logic [3:0] d; int due;} ret_t;
  ret_t dq[$], bq[$];
  int cyc;
  logic [3:0] last_dd, last_bd;
  task automatic tick_sb();
    bit ed, eb;
    #2;
    chk("sb_gnt", bg_gnt, bg_req && !disp_req);
    ed = dq.size() > 0 && dq[0].due == cyc;
    eb = bq.size() > 0 && bq[0].due == cyc;
    chk("sb_dv", disp_valid, ed);
    chk("sb_bv", bg_valid, eb);
    if (ed) begin last_dd = dq[0].d; void'(dq.pop_front()); end
    if (eb) begin last_bd = bq[0].d; void'(bq.pop_front()); end
    chk("sb_dd", disp_data, last_dd);
    chk("sb_bd", bg_data, last_bd);
    if (disp_req) dq.push_back('{rom_f(disp_addr), cyc + 3});
    else if (bg_req) bq.push_back('{rom_f(bg_addr), cyc + 3});
    @(negedge clk);
    cyc++;
  endtask
  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    int found;
    logic [3:0] got;
    bit pend;
    tbl[0]  = '{1'b1, 9'h041, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 4'h0, 1'b0, 4'h0};
    tbl[1]  = '{1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 9'h041, 1'b0, 4'h0, 1'b0, 4'h0};
    tbl[2]  = tbl[1];
    tbl[3]  = '{1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 9'h041, 1'b1, 4'hA, 1'b0, 4'h0};
    tbl[4]  = '{1'b0, 9'h000, 1'b1, 9'h100, 1'b1, 9'h041, 1'b0, 4'hA, 1'b0, 4'h0};
    tbl[5]  = '{1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 9'h100, 1'b0, 4'hA, 1'b0, 4'h0};
    tbl[6]  = tbl[5];
    tbl[7]  = '{1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 9'h100, 1'b0, 4'hA, 1'b1, 4'hE};
    tbl[8]  = '{1'b1, 9'h0F3, 1'b1, 9'h022, 1'b0, 9'h100, 1'b0, 4'hA, 1'b0, 4'hE};
    tbl[9]  = '{1'b0, 9'h000, 1'b1, 9'h022, 1'b1, 9'h0F3, 1'b0, 4'hA, 1'b0, 4'hE};
    tbl[10] = '{1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 9'h022, 1'b0, 4'hA, 1'b0, 4'hE};
    tbl[11] = '{1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 9'h022, 1'b1, 4'h3, 1'b0, 4'hE};
    tbl[12] = '{1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 9'h022, 1'b0, 4'h3, 1'b1, 4'hF};
    tbl[13] = '{1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 9'h022, 1'b0, 4'h3, 1'b0, 4'hF};
    repeat (2) @(negedge clk);
    bg_req = 1'b1;
    #2;
    chk("rst_ra", rom_addr, 0);
    chk("rst_gnt", bg_gnt, 0);
    chk("rst_dv", disp_valid, 0);
    chk("rst_bv", bg_valid, 0);
    chk("rst_dd", disp_data, 0);
    chk("rst_bd", bg_data, 0);
    @(negedge clk);
    bg_req = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      disp_req = tbl[i].dr; disp_addr = tbl[i].da; bg_req = tbl[i].br; bg_addr = tbl[i].ba;
      #2;
      chk($sformatf("v%0d_gnt", i), bg_gnt, tbl[i].gnt);
      chk($sformatf("v%0d_ra", i), rom_addr, tbl[i].ra);
      chk($sformatf("v%0d_dv", i), disp_valid, tbl[i].dv);
      chk($sformatf("v%0d_dd", i), disp_data, tbl[i].dd);
      chk($sformatf("v%0d_bv", i), bg_valid, tbl[i].bv);
      chk($sformatf("v%0d_bd", i), bg_data, tbl[i].bd);
      @(negedge clk);
    end
    disp_req = 1'b1; disp_addr = 9'h041; bg_req = 1'b0;
    @(negedge clk);
    disp_req = 1'b0; bg_req = 1'b1; rst = 1'b1;
    #2;
    chk("midrst_ra", rom_addr, 0);
    chk("midrst_gnt", bg_gnt, 0);
    chk("midrst_dd", disp_data, 0);
    chk("midrst_bd", bg_data, 0);
    @(negedge clk);
    rst = 1'b0; bg_req = 1'b0;
    for (int n = 0; n < 4; n++) begin
      #2;
      chk("flush_dv", disp_valid, 0);
      chk("flush_bv", bg_valid, 0);
      chk("flush_dd", disp_data, 0);
      @(negedge clk);
    end
    disp_req = 1'b1; disp_addr = 9'h0F3;
    @(negedge clk);
    disp_req = 1'b0;
    found = 0; got = '0;
    for (int n = 1; n <= 6; n++) begin
      #2;
      if (disp_valid && found == 0) begin found = n; got = disp_data; end
      @(negedge clk);
    end
    chk("recover_lat", found, 3);
    chk("recover_data", got, 4'h3);
    pulse_rst();
    bg_req = 1'b1; bg_addr = 9'h100; disp_req = 1'b1; disp_addr = 9'h041;
    for (int n = 0; n < 5; n++) begin
      #2;
      chk("stall_gnt", bg_gnt, 0);
      @(negedge clk);
    end
    disp_req = 1'b0;
    #2;
    chk("stall_release_gnt", bg_gnt, 1);
    @(negedge clk);
    bg_req = 1'b0;
`ifdef FONT_ARB_STATS_EN
    chk("stall_cnt", cnt, 5);
`endif
    for (int n = 1; n <= 4; n++) begin
      #2;
      chk("stall_bv", bg_valid, n == 3);
      if (n == 3) chk("stall_bd", bg_data, 4'hE);
      @(negedge clk);
    end
    bg_req3 = 1'b1; bg_addr3 = 9'h041;
    #2;
    chk("l3_gnt", gnt3, 1);
    @(negedge clk);
    bg_req3 = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      #2;
      chk("l3_bv", bv3, n == 5);
      chk("l3_dv", dv3, 0);
      if (n == 5) chk("l3_bd", bd3, 4'hA);
      @(negedge clk);
    end
`ifdef FONT_ARB_STATS_EN
    pulse_rst();
    bg_req = 1'b1; disp_req = 1'b1;
    repeat (70000) @(negedge clk);
    #2;
    chk("sat_cnt", cnt, 16'hFFFF);
    @(negedge clk);
    #2;
    chk("sat_hold", cnt, 16'hFFFF);
    @(negedge clk);
    bg_req = 1'b0; disp_req = 1'b0;
`endif
    pulse_rst();
    cyc = 0; last_dd = '0; last_bd = '0; pend = 1'b0;
    for (int i = 0; i < 8; i++) begin
      disp_req = (i % 2 == 0); bg_req = (i % 2 == 1);
      disp_addr = 9'(i); bg_addr = 9'(i);
      tick_sb();
    end
    disp_req = 1'b0; bg_req = 1'b0;
    repeat (4) tick_sb();
    chk("alt_dq_empty", dq.size(), 0);
    chk("alt_bq_empty", bq.size(), 0);
    for (int i = 0; i < 3000; i++) begin
      disp_req = ($urandom_range(9) < 4);
      disp_addr = 9'($urandom);
      if (!pend) begin
        bg_req = 1'($urandom_range(1));
        bg_addr = 9'($urandom);
      end
      pend = bg_req && disp_req;
      tick_sb();
    end
    disp_req = 1'b0; bg_req = 1'b0;
    repeat (4) tick_sb();
    chk("rnd_dq_empty", dq.size(), 0);
    chk("rnd_bq_empty", bq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
